// File: rtl/rr_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_seq_pkg
//  Description : Shared constants and FSM state type for the round-robin
//                channel sequencer and its priority picker.
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_seq_pkg;

    localparam int NUM_CH = 16;
    localparam int IDX_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_pick
//  Description : Combinational wrap-around priority picker. Returns the first
//                set request bit at or above ptr, wrapping past the top
//                channel back to channel 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick
    import rr_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  idx,
    output logic              found
);

    logic [2*NUM_CH-1:0] w_dbl;
    logic [NUM_CH-1:0]   w_rot;
    logic [IDX_W-1:0]    w_off;

    // Rotate so that channel ptr lands at bit 0; the doubled vector supplies
    // the wrapped-around upper channels.
    assign w_dbl = {req, req} >> ptr;
    assign w_rot = w_dbl[NUM_CH-1:0];

    // Priority-encode the lowest set bit of the rotated vector.
    always_comb begin
        w_off = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    // Un-rotate: the modulo-NUM_CH add wraps naturally in IDX_W bits.
    assign idx   = w_off + ptr;
    assign found = |req;

endmodule
`default_nettype wire

// File: rtl/rr_channel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rr_channel_sequencer
//  Description : Round-robin sequencer feeding a 4-to-16 one-hot decoder.
//                Grants one requesting channel for a programmable number of
//                cycles, then inserts a dead cycle so decoder selects never
//                overlap between consecutive grants. All outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_channel_sequencer
    import rr_seq_pkg::*;
#(
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req_in,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic              release_in,
    output logic [IDX_W-1:0]  binary_out,
    output logic              enable_out,
    output logic              grant_start,
    output logic              busy
);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;

    logic [IDX_W-1:0]  r_last_idx;
    logic [IDX_W-1:0]  r_binary;
    logic              r_enable;
    logic              r_grant_start;
    logic              r_busy;
    logic [HOLD_W-1:0] r_hold_len;
    logic [HOLD_W-1:0] r_hold_cnt;

    logic [IDX_W-1:0]  w_last_nxt;
    logic [IDX_W-1:0]  w_binary_nxt;
    logic              w_enable_nxt;
    logic              w_grant_start_nxt;
    logic              w_busy_nxt;
    logic [HOLD_W-1:0] w_hold_len_nxt;
    logic [HOLD_W-1:0] w_hold_cnt_nxt;

    logic [IDX_W-1:0]  w_ptr;
    logic [IDX_W-1:0]  w_pick;
    logic              w_found;
    logic [HOLD_W-1:0] w_hold_eff;
    logic              w_grant_done;

    // Search starts one past the last granted channel; wraps 15 -> 0.
    assign w_ptr = r_last_idx + IDX_W'(1);

    rr_priority_pick u_pick (
        .req   (req_in),
        .ptr   (w_ptr),
        .idx   (w_pick),
        .found (w_found)
    );

    // A zero hold request still yields a one-cycle grant.
    assign w_hold_eff = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;

    // Grant ends on the last counted cycle or on an early release; both
    // together still produce a single exit. hold_len is never 0 here.
    assign w_grant_done = (r_hold_cnt == (r_hold_len - HOLD_W'(1))) || release_in;

    // State and output registers; reset clears everything at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_last_idx    <= IDX_W'(NUM_CH - 1);
            r_binary      <= '0;
            r_enable      <= 1'b0;
            r_grant_start <= 1'b0;
            r_busy        <= 1'b0;
            r_hold_len    <= '0;
            r_hold_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_last_idx    <= w_last_nxt;
            r_binary      <= w_binary_nxt;
            r_enable      <= w_enable_nxt;
            r_grant_start <= w_grant_start_nxt;
            r_busy        <= w_busy_nxt;
            r_hold_len    <= w_hold_len_nxt;
            r_hold_cnt    <= w_hold_cnt_nxt;
        end
    end

    // Next-state decode: IDLE -> GRANT on any request, GRANT -> GAP on
    // completion, GAP always lasts exactly one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_found)      w_state_nxt = GRANT;
            GRANT:   if (w_grant_done) w_state_nxt = GAP;
            GAP:                       w_state_nxt = IDLE;
            default:                   w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and grant bookkeeping.
    always_comb begin
        w_last_nxt        = r_last_idx;
        w_binary_nxt      = r_binary;
        w_hold_len_nxt    = r_hold_len;
        w_hold_cnt_nxt    = r_hold_cnt;
        w_grant_start_nxt = 1'b0;
        w_enable_nxt      = (w_state_nxt == GRANT);
        w_busy_nxt        = (w_state_nxt != IDLE);
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_binary_nxt      = w_pick;
                    w_last_nxt        = w_pick;
                    w_hold_len_nxt    = w_hold_eff;
                    w_hold_cnt_nxt    = '0;
                    w_grant_start_nxt = 1'b1;
                end
            end
            GRANT: begin
                // Peaks at hold_len (<= 255), so the counter never wraps.
                w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
            end
            default: begin
            end
        endcase
    end

    assign binary_out  = r_binary;
    assign enable_out  = r_enable;
    assign grant_start = r_grant_start;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rr_channel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_channel_sequencer
//  Description : Self-checking bench for rr_channel_sequencer: fixed vector
//                table, hand-written corner sequences and randomized traffic
//                against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_channel_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] req_in = '0;
    logic [7:0]  hold_cycles = '0;
    logic        release_in = 1'b0;
    logic [3:0]  binary_out;
    logic        enable_out;
    logic        grant_start;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: a grant is described by how many enabled
    // cycles remain, plus a flag for the pending dead cycle.
    int m_idx, m_last, m_remaining;
    bit m_en, m_gs, m_busy, m_gap;

    typedef struct {
        bit          rst;
        logic [15:0] req;
        logic [7:0]  hold;
        bit          rel;
        int          e_bin;
        bit          e_en;
        bit          e_gs;
        bit          e_busy;
    } vec_t;

    vec_t vt[16];

    rr_channel_sequencer #(.HOLD_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_in      (req_in),
        .hold_cycles (hold_cycles),
        .release_in  (release_in),
        .binary_out  (binary_out),
        .enable_out  (enable_out),
        .grant_start (grant_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the specified behaviour, using inputs as sampled.
    task automatic model_edge();
        m_gs = 1'b0;
        if (reset) begin
            m_idx = 0; m_last = 15; m_remaining = 0;
            m_en = 0; m_busy = 0; m_gap = 0;
        end else if (m_remaining > 0) begin
            if (release_in || m_remaining == 1) begin
                m_remaining = 0;
                m_en  = 0;
                m_gap = 1;
            end else begin
                m_remaining--;
            end
        end else if (m_gap) begin
            m_gap  = 0;
            m_busy = 0;
        end else begin
            for (int k = 1; k <= 16; k++) begin
                int c;
                c = (m_last + k) % 16;
                if (req_in[c]) begin
                    m_idx = c; m_last = c;
                    m_en = 1; m_gs = 1; m_busy = 1;
                    m_remaining = (hold_cycles == 0) ? 1 : int'(hold_cycles);
                    break;
                end
            end
        end
    endtask

    // Advance one cycle and compare all outputs against the model.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_binary_out", binary_out, m_idx);
        chk("model_enable_out", enable_out, m_en);
        chk("model_grant_start", grant_start, m_gs);
        chk("model_busy", busy, m_busy);
    endtask

    task automatic do_reset();
        reset = 1'b1; release_in = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int grants[$];
        int exp_order[5];
        int budget;
        int prev_bin;
        bit prev_en;

        m_idx = 0; m_last = 15; m_remaining = 0;
        m_en = 0; m_gs = 0; m_busy = 0; m_gap = 0;

        // rst, req, hold, rel -> bin, en, gs, busy
        vt[0]  = '{1, 16'h0000, 8'd3,  0, 0,  0, 0, 0};
        vt[1]  = '{0, 16'h0001, 8'd3,  0, 0,  1, 1, 1};
        vt[2]  = '{0, 16'h0001, 8'd3,  0, 0,  1, 0, 1};
        vt[3]  = '{0, 16'h0001, 8'd3,  0, 0,  1, 0, 1};
        vt[4]  = '{0, 16'h0001, 8'd3,  0, 0,  0, 0, 1};
        vt[5]  = '{0, 16'h0001, 8'd3,  0, 0,  0, 0, 0};
        vt[6]  = '{0, 16'h0001, 8'd3,  0, 0,  1, 1, 1};
        vt[7]  = '{1, 16'h0000, 8'd10, 0, 0,  0, 0, 0};
        vt[8]  = '{0, 16'h0020, 8'd10, 0, 5,  1, 1, 1};
        vt[9]  = '{0, 16'h0020, 8'd10, 0, 5,  1, 0, 1};
        vt[10] = '{0, 16'h0020, 8'd10, 0, 5,  1, 0, 1};
        vt[11] = '{0, 16'h0020, 8'd10, 1, 5,  0, 0, 1};
        vt[12] = '{0, 16'h0000, 8'd10, 0, 5,  0, 0, 0};
        vt[13] = '{0, 16'h0400, 8'd0,  0, 10, 1, 1, 1};
        vt[14] = '{0, 16'h0000, 8'd0,  0, 10, 0, 0, 1};
        vt[15] = '{0, 16'h0000, 8'd0,  0, 10, 0, 0, 0};

        #2;
        // Vector table: lone requester re-grant, early release, hold of 0.
        for (int i = 0; i < 16; i++) begin
            reset = vt[i].rst; req_in = vt[i].req;
            hold_cycles = vt[i].hold; release_in = vt[i].rel;
            step();
            chk($sformatf("vt%0d_binary_out", i), binary_out, vt[i].e_bin);
            chk($sformatf("vt%0d_enable_out", i), enable_out, vt[i].e_en);
            chk($sformatf("vt%0d_grant_start", i), grant_start, vt[i].e_gs);
            chk($sformatf("vt%0d_busy", i), busy, vt[i].e_busy);
        end
        release_in = 1'b0;

        // Idle with no requests: nothing moves for 10 cycles.
        req_in = '0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_outputs", {binary_out, enable_out, busy}, 6'd0);
        end

        // Round-robin with wrap: 0, 4, 15, 0, 4 and no overlapping selects.
        hold_cycles = 8'd2; req_in = 16'h8011;
        exp_order = '{0, 4, 15, 0, 4};
        prev_en = 0; prev_bin = 0; budget = 0;
        while (grants.size() < 5 && budget < 100) begin
            step();
            budget++;
            if (grant_start) grants.push_back(int'(binary_out));
            if (prev_en && enable_out)
                chk("rr_no_overlap", binary_out, prev_bin);
            prev_en = enable_out; prev_bin = int'(binary_out);
        end
        chk("rr_grant_count", grants.size(), 5);
        for (int i = 0; i < grants.size() && i < 5; i++)
            chk($sformatf("rr_order%0d", i), grants[i], exp_order[i]);

        // Reset in the middle of a grant, then restart from channel 0 side.
        req_in = '0;
        do_reset();
        hold_cycles = 8'd8; req_in = 16'h0004;
        for (int i = 0; i < 4; i++) step();
        chk("midgrant_active_bin", binary_out, 2);
        chk("midgrant_active_en", enable_out, 1);
        reset = 1'b1;
        step();
        chk("midgrant_reset_out", {binary_out, enable_out, busy}, 6'd0);
        reset = 1'b0; req_in = 16'h0006;
        step();
        chk("post_reset_pick", binary_out, 1);
        chk("post_reset_gs", grant_start, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            req_in      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom & $urandom);
            hold_cycles = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
            release_in  = ($urandom_range(0, 7) == 0);
            step();
            if (m_remaining > 300) chk("random_budget", m_remaining, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute safety net so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/rr_channel_sequencer.md
Name: rr_channel_sequencer

Overview:
- Round-robin channel sequencer that sits directly upstream of the 4-to-16 one-hot decoder.
- Arbitrates among 16 channel requests and emits a registered 4-bit channel index plus an enable.
- Holds each grant for a programmable number of cycles, then inserts one dead cycle before the next grant, so downstream one-hot selects never overlap between grants.

Parameters:
- NUM_CH, 16, number of request channels; fixed to the decoder's output width.
- IDX_W, 4, channel index width; equals log2(NUM_CH).
- HOLD_W, 8, width of the hold-length input and the internal hold counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_in  input  16  per-channel request; bit i = channel i wants service; level-sensitive.
- hold_cycles  input  HOLD_W  grant length in cycles; sampled at grant start; 0 is treated as 1.
- release_in  input  1  early-release strobe; honoured in GRANT only.
- binary_out  output  IDX_W  granted channel index; feeds the decoder's binary input.
- enable_out  output  1  high while a grant is active; feeds the decoder's enable.
- grant_start  output  1  one-cycle pulse on the first cycle of each grant.
- busy  output  1  high in GRANT and GAP.

Behaviour:
- All outputs are registered.
- Reset values: binary_out=0, enable_out=0, grant_start=0, busy=0, state=IDLE, last_idx=15, hold_cnt=0.
  - last_idx=15 makes the first search after reset start at channel 0.
- Reset is synchronous. If reset is high at any edge, including mid-grant, all state and outputs take their reset values at that edge.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If req_in==0, stay in IDLE.
  - Otherwise, pick the first set bit searching upward from (last_idx+1) mod 16, wrapping 15->0.
  - At the same edge: binary_out<=pick, last_idx<=pick, enable_out<=1, grant_start<=1, busy<=1.
  - Load hold_len<=max(hold_cycles,1), hold_cnt<=0, go to GRANT.
  - Latency: req_in sampled at edge N gives enable_out high after edge N (1 cycle).
- GRANT:
  - hold_cnt increments each cycle; grant_start=0.
  - Exit when hold_cnt==hold_len-1 or release_in=1. If both occur in the same cycle, exit once.
  - On exit: enable_out<=0, go to GAP. binary_out keeps its last value.
  - The granted channel dropping its req_in does not end the grant.
  - Changes to hold_cycles during GRANT are ignored.
  - enable_out is high for exactly hold_len cycles unless released early. Minimum grant length is 1 cycle.
- GAP:
  - Exactly one cycle with enable_out=0 and busy=1, then go to IDLE.
  - release_in is ignored; req_in is not sampled.
- Fairness:
  - A channel cannot be re-granted while any other channel is requesting.
  - A lone requester equal to last_idx is re-granted after GAP + IDLE.
  - Back-to-back grant period = hold_len + 2 cycles.
- release_in is ignored in IDLE and GAP.
- Arithmetic:
  - hold_cnt is HOLD_W bits and never wraps, because exit occurs at hold_len-1 ≤ 254 (hold_len maximum is 255).
  - The pointer search is modulo 16.

Decomposition:
- Shared package rr_seq_pkg:
  - constants NUM_CH=16, IDX_W=4;
  - typedef enum logic [1:0] {IDLE, GRANT, GAP} seq_state_t.
- One natural sub-module, rr_priority_pick (combinational):
  - inputs req[15:0] and ptr[3:0];
  - outputs idx[3:0] and found;
  - returns the first set bit at or above ptr, with wrap-around;
  - implementation: rotate, priority-encode, un-rotate.

Test Plan:
- Reset then req_in=16'h0000 for 10 cycles -> enable_out=0, busy=0, binary_out=0 throughout.
- Reset, hold_cycles=3, req_in=16'h0001 held -> binary_out=0, enable_out high 3 cycles, 1 low GAP cycle, 1 IDLE cycle, then re-grant of channel 0; grant_start pulses once per grant.
- hold_cycles=2, req_in=16'h8011 held -> grant order 0, 4, 15, 0, 4 (wrap 15->0); enable_out never high across two different binary_out values without a low cycle between.
- hold_cycles=10, req_in=16'h0020, release_in pulsed on the 3rd GRANT cycle -> enable_out high exactly 3 cycles, then GAP; binary_out=5.
- hold_cycles=0, req_in=16'h0400 -> enable_out high 1 cycle, binary_out=10.
- hold_cycles=8, grant to channel 2 active, reset asserted on the 4th GRANT cycle -> next edge: enable_out=0, busy=0, binary_out=0; after reset, req_in=16'h0006 grants channel 1 first.
